// File: rtl/hack_boot_pkg.sv
// Shared types and constants for the Hack instruction-ROM boot loader.
package hack_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StDataHi,
        StDataLo,
        StWrite,
        StRelease,
        StError
    } boot_state_e;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/boot_timeout_timer.sv
// Inactivity timer: counts enabled cycles since the last clear and flags when TIMEOUT is reached.
module boot_timeout_timer
    import hack_boot_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = cnt_width(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end
    end

    // High in the cycle whose closing edge would bring the count to TIMEOUT.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/hack_boot_loader.sv
// Loads big-endian 16-bit words from a byte stream into the Hack instruction ROM
// while holding the CPU in reset, then releases it after a settle delay.
module hack_boot_loader
    import hack_boot_pkg::*;
#(
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned TIMEOUT       = 1000000,
    parameter int unsigned RELEASE_DELAY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [WORD_W-1:0] prog_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned        CNT_W    = cnt_width(2 ** ADDR_W);
    localparam int unsigned        REL_W    = cnt_width(RELEASE_DELAY);
    localparam logic [WORD_W:0]    CAPACITY = (WORD_W + 1)'(2 ** ADDR_W);

    boot_state_e       state, state_d;
    logic [WORD_W-1:0] word_n;
    logic [CNT_W-1:0]  word_cnt;
    logic [REL_W-1:0]  rel_cnt;
    logic [WORD_W-1:0] n_hdr;
    logic              take, expired, timer_clear, last_word, rel_done, entering_hdr;

    // A timed-out byte is never consumed.
    assign take         = rx_valid && rx_ready && !expired;
    assign n_hdr        = {word_n[WORD_W-1:BYTE_W], rx_data};
    assign last_word    = (WORD_W'(word_cnt) + WORD_W'(1)) == word_n;
    assign rel_done     = rel_cnt == REL_W'(RELEASE_DELAY - 1);
    assign entering_hdr = (state_d == StHdrHi) && (state != StHdrHi);
    assign timer_clear  = take || entering_hdr;

    boot_timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (rx_ready),
        .expired(expired)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            StIdle:    if (start) state_d = StHdrHi;
            StHdrHi:   if (expired) state_d = StError; else if (take) state_d = StHdrLo;
            StHdrLo: begin
                if (expired) begin
                    state_d = StError;
                end else if (take) begin
                    if (n_hdr == '0)                     state_d = StRelease;
                    else if ({1'b0, n_hdr} > CAPACITY)   state_d = StError;
                    else                                 state_d = StDataHi;
                end
            end
            StDataHi:  if (expired) state_d = StError; else if (take) state_d = StDataLo;
            StDataLo:  if (expired) state_d = StError; else if (take) state_d = StWrite;
            StWrite:   state_d = last_word ? StRelease : StDataHi;
            StRelease: if (rel_done) state_d = StIdle;
            StError:   if (start) state_d = StHdrHi;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            rx_ready   <= 1'b0;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_wdata <= '0;
            cpu_reset  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_n     <= '0;
            word_cnt   <= '0;
            rel_cnt    <= '0;
        end else begin
            state     <= state_d;
            rx_ready  <= state_d inside {StHdrHi, StHdrLo, StDataHi, StDataLo};
            prog_we   <= state_d == StWrite;
            busy      <= state_d inside {StHdrHi, StHdrLo, StDataHi, StDataLo, StWrite, StRelease};
            cpu_reset <= state_d inside {StHdrHi, StHdrLo, StDataHi, StDataLo, StWrite, StRelease,
                                         StError};
            done      <= (state == StRelease) && (state_d == StIdle);
            error     <= state_d == StError;

            if (take) begin
                unique case (state)
                    StHdrHi:  word_n[WORD_W-1:BYTE_W]     <= rx_data;
                    StHdrLo:  word_n[BYTE_W-1:0]          <= rx_data;
                    StDataHi: prog_wdata[WORD_W-1:BYTE_W] <= rx_data;
                    StDataLo: prog_wdata[BYTE_W-1:0]      <= rx_data;
                    default:  ;
                endcase
            end

            if (entering_hdr) begin
                prog_addr <= '0;
                word_cnt  <= '0;
            end else if (state == StWrite) begin
                prog_addr <= prog_addr + ADDR_W'(1);
                word_cnt  <= word_cnt + CNT_W'(1);
            end

            rel_cnt <= (state == StRelease) ? rel_cnt + REL_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed self-checking bench for hack_boot_loader (ADDR_W=4, TIMEOUT=20, RELEASE_DELAY=4).
module tb_hack_boot_loader;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, prog_we, cpu_reset, busy, done, error;
    logic [3:0]  prog_addr;
    logic [15:0] prog_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    // Write/done log filled on falling edges.
    logic [3:0]  wr_addr [64];
    logic [15:0] wr_data [64];
    int          wr_n   = 0;
    int          done_n = 0;

    logic [15:0] full_data [16] = '{16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE,
                                    16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                    16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0,
                                    16'h0102, 16'h0304, 16'hCAFE, 16'hBEEF};

    hack_boot_loader #(
        .ADDR_W       (4),
        .TIMEOUT      (20),
        .RELEASE_DELAY(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (prog_we && wr_n < 64) begin
                wr_addr[wr_n] = prog_addr;
                wr_data[wr_n] = prog_wdata;
                wr_n++;
            end
            if (done) done_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Holds a byte valid until it is accepted; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap = 0, input bit poke = 1'b0);
        int n;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            start = poke && (g == 0);
            @(negedge clk);
        end
        start    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check_eq("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (cpu_reset && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, wr0, dn0;
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_eq("rst_rx_ready",   {31'b0, rx_ready},  0);
        check_eq("rst_prog_we",    {31'b0, prog_we},   0);
        check_eq("rst_prog_addr",  {28'b0, prog_addr}, 0);
        check_eq("rst_prog_wdata", {16'b0, prog_wdata}, 0);
        check_eq("rst_cpu_reset",  {31'b0, cpu_reset}, 0);
        check_eq("rst_busy",       {31'b0, busy},      0);
        check_eq("rst_done",       {31'b0, done},      0);
        check_eq("rst_error",      {31'b0, error},     0);

        // Nominal three-word load with the stream always valid.
        wr0 = wr_n; dn0 = done_n;
        pulse_start();
        check_eq("nom_cpu_reset_hdr", {31'b0, cpu_reset}, 1);
        check_eq("nom_busy_hdr",      {31'b0, busy},      1);
        check_eq("nom_rx_ready_hdr",  {31'b0, rx_ready},  1);
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h00); send_byte(8'h07);
        check_eq("nom_last_we",    {31'b0, prog_we},    1);
        check_eq("nom_last_addr",  {28'b0, prog_addr},  2);
        check_eq("nom_last_wdata", {16'b0, prog_wdata}, 32'h0007);
        @(negedge clk);
        wait_release(n);
        check_eq("nom_release_len", n, 4);
        check_eq("nom_done",        {31'b0, done},  1);
        check_eq("nom_busy_end",    {31'b0, busy},  0);
        @(negedge clk);
        check_eq("nom_done_pulse",  {31'b0, done},  0);
        check_eq("nom_error",       {31'b0, error}, 0);
        check_eq("nom_writes",      wr_n - wr0, 3);
        check_eq("nom_done_count",  done_n - dn0, 1);
        check_eq("nom_a0", {28'b0, wr_addr[wr0]},     0);
        check_eq("nom_d0", {16'b0, wr_data[wr0]},     32'h1234);
        check_eq("nom_a1", {28'b0, wr_addr[wr0 + 1]}, 1);
        check_eq("nom_d1", {16'b0, wr_data[wr0 + 1]}, 32'hABCD);
        check_eq("nom_a2", {28'b0, wr_addr[wr0 + 2]}, 2);
        check_eq("nom_d2", {16'b0, wr_data[wr0 + 2]}, 32'h0007);

        // Zero-length load goes straight to release.
        wr0 = wr_n; dn0 = done_n;
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        check_eq("zero_cpu_reset", {31'b0, cpu_reset}, 1);
        wait_release(n);
        check_eq("zero_release_len", n, 4);
        check_eq("zero_done", {31'b0, done}, 1);
        @(negedge clk);
        check_eq("zero_writes", wr_n - wr0, 0);
        check_eq("zero_done_count", done_n - dn0, 1);

        // Oversize header (17 > 16 words) traps in ERROR.
        wr0 = wr_n;
        pulse_start();
        send_byte(8'h00); send_byte(8'h11);
        repeat (3) @(negedge clk);
        check_eq("ovr_error",     {31'b0, error},     1);
        check_eq("ovr_cpu_reset", {31'b0, cpu_reset}, 1);
        check_eq("ovr_busy",      {31'b0, busy},      0);
        check_eq("ovr_rx_ready",  {31'b0, rx_ready},  0);
        check_eq("ovr_writes",    wr_n - wr0, 0);
        pulse_start();
        check_eq("rec_error_clr", {31'b0, error}, 0);
        check_eq("rec_busy",      {31'b0, busy},  1);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF);
        @(negedge clk);
        wait_release(n);
        check_eq("rec_done", {31'b0, done}, 1);
        @(negedge clk);
        check_eq("rec_writes", wr_n - wr0, 1);
        check_eq("rec_d0",     {16'b0, wr_data[wr0]}, 32'hBEEF);
        check_eq("rec_error",  {31'b0, error}, 0);

        // Stall after the first data byte: ERROR exactly 20 cycles after it was accepted.
        wr0 = wr_n;
        pulse_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        n = 0;
        while (!error && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_cycles",    n, 20);
        check_eq("to_rx_ready",  {31'b0, rx_ready},  0);
        check_eq("to_cpu_reset", {31'b0, cpu_reset}, 1);
        check_eq("to_writes",    wr_n - wr0, 0);

        // Full 16-word load from ERROR with gaps and ignored mid-load start pulses.
        wr0 = wr_n; dn0 = done_n;
        pulse_start();
        send_byte(8'h00, 3); send_byte(8'h10, 7);
        for (int i = 0; i < 16; i++) begin
            send_byte(full_data[i][15:8], int'($urandom_range(1, 12)), (i == 5) || (i == 11));
            send_byte(full_data[i][7:0],  int'($urandom_range(0, 12)));
        end
        check_eq("full_last_we",   {31'b0, prog_we},   1);
        check_eq("full_last_addr", {28'b0, prog_addr}, 15);
        @(negedge clk);
        check_eq("full_addr_wrap", {28'b0, prog_addr}, 0);
        wait_release(n);
        check_eq("full_release_len", n, 4);
        @(negedge clk);
        check_eq("full_writes",     wr_n - wr0, 16);
        check_eq("full_done_count", done_n - dn0, 1);
        check_eq("full_error",      {31'b0, error}, 0);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("full_a%0d", i), {28'b0, wr_addr[wr0 + i]}, i);
            check_eq($sformatf("full_d%0d", i), {16'b0, wr_data[wr0 + i]}, {16'b0, full_data[i]});
        end

        // Reset asserted while the loader sits in DATA_LO.
        pulse_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        check_eq("mid_rx_ready_pre", {31'b0, rx_ready}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_cpu_reset", {31'b0, cpu_reset}, 0);
        check_eq("mid_busy",      {31'b0, busy},      0);
        check_eq("mid_rx_ready",  {31'b0, rx_ready},  0);
        check_eq("mid_prog_we",   {31'b0, prog_we},   0);
        check_eq("mid_error",     {31'b0, error},     0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
